collision_event_scheduler: RTL and testbench
============================================

# collision_event_scheduler

Collects per-pixel collision pulses produced by the VGA pixel pipeline during active video. At each `frame` pulse it snapshots one frame's worth of hits and serializes them to the game-state logic as a stream of events over a valid/ready handshake. The game logic therefore sees each collision exactly once per frame, in a fixed priority order, instead of a burst of repeated pixel-level pulses. The block sits between the VGA controller outputs (`frame`, `invader_collision`, `player_collision`) and the game update FSM.

## Interface
- `NUM_INVADERS`, default 55: number of invader slots. Valid invader indices are 1..NUM_INVADERS.
- `NUM_MISSILES`, default 3: number of invader missiles. Valid missile indices are 1..NUM_MISSILES.
- `clk` in, 1: pixel clock.
- `rst` in, 1: reset, asynchronous, active-high. Clock is `clk`.
- `frame` in, 1: single-cycle pulse at the start of the blanking interval.
- `invader_collision` in, 6: 0 means no hit; k means the laser hit invader k this cycle.
- `player_collision` in, 2: 0 means no hit; m means missile m hit the player this cycle.
- `ev_valid` out, 1: an event is presented.
- `ev_ready` in, 1: the consumer accepts the event.
- `ev_type` out, 1: 0 = invader hit, 1 = player hit.
- `ev_index` out, 6: invader index (1..55) or missile index (1..3).
- `busy` out, 1: the scheduler is not in IDLE.
- `overrun` out, 1: one-cycle pulse when a frame snapshot is dropped.

## Operation
- **Capture registers**
  - `cap_inv` (6 b): index of the first invader hit this frame.
  - `cap_inv_v` (1 b): `cap_inv` holds a hit.
  - `cap_ply` (NUM_MISSILES b): one bit per missile.
- **Invader capture**
  - Only the first nonzero, in-range `invader_collision` of a frame is stored; the laser destroys one invader.
  - Later invader hits in the same frame are ignored, even with a different index.
  - Values above NUM_INVADERS are ignored and do not set `cap_inv_v`.
- **Player capture**
  - Nonzero, in-range `player_collision` value m sets `cap_ply[m-1]`.
  - Repeats of the same m are idempotent.
- **On a `frame` pulse, FSM in IDLE**
  - Copy the capture registers into the pending registers (`pend_inv`, `pend_inv_v`, `pend_ply`).
  - Clear the capture registers in the same cycle.
  - A collision input asserted in the same cycle as `frame` goes into the cleared capture registers, i.e. it counts toward the next frame.
- **On a `frame` pulse, FSM not in IDLE**
  - The snapshot is discarded and the capture registers are still cleared.
  - `overrun` pulses for 1 cycle.
  - The pending drain continues unaffected.
- **FSM states: IDLE, EMIT_INV, EMIT_PLY**
  - IDLE → EMIT_INV on `frame` if snapshot `cap_inv_v`=1.
  - IDLE → EMIT_PLY on `frame` if `cap_inv_v`=0 and `cap_ply`≠0.
  - Otherwise the FSM stays in IDLE.
  - EMIT_INV: `ev_type`=0, `ev_index`=`pend_inv`.
  - EMIT_INV, on handshake: go to EMIT_PLY if `pend_ply`≠0, else IDLE.
  - EMIT_PLY: present the lowest set bit b of `pend_ply` as `ev_type`=1, `ev_index`=b+1.
  - EMIT_PLY, on handshake: clear bit b; go to IDLE when no bits remain, else stay and present the next bit.
- **Handshake**
  - A transfer occurs when `ev_valid` && `ev_ready` are both high at a rising edge.
  - `ev_valid`=1 exactly in EMIT_INV/EMIT_PLY.
  - `ev_type` and `ev_index` are stable while `ev_valid`=1 and `ev_ready`=0.
  - `ev_ready` is ignored while `ev_valid`=0.
- **Outputs**
  - `ev_index`=0 and `ev_type`=0 while in IDLE.
  - `busy` = (state ≠ IDLE).
- **Width rules**
  - All index comparisons are unsigned.
  - Missile bit index = `player_collision` − 1, with 2 bits.

## Timing
- **Reset:** every output, the capture registers and the pending registers are 0; state = IDLE. Asserting `rst` mid-drain abandons all pending events immediately.
- **Snapshot latency:** `frame` sampled at edge N gives `ev_valid`=1 after edge N (first event visible in cycle N+1).
- **Throughput:** with `ev_ready` held high, one event per cycle. A frame with an invader hit plus k missile hits drains in 1+k cycles, then `busy`=0 on the following cycle.
- **Event order:** the invader event always precedes player events. Player events go in ascending missile index.
- **Overrun timing:** `overrun` is registered and high for exactly the cycle after the offending `frame` edge.
- **Capture during drain:** hits arriving while draining accumulate normally into the capture registers for the next snapshot.

## Test plan
- **Invader hit then repeats:** invader_collision=17 for 4 cycles, then =20 for 2 cycles, then frame, ev_ready=1 → exactly one event {type 0, index 17}; busy returns to 0 two cycles after frame.
- **Mixed hits with back-pressure:** player_collision=3, then =1, invader_collision=5, then frame; ev_ready low for 3 cycles then high → events {0,5}, {1,1}, {1,3} in that order; payload held stable during the stall.
- **Invalid and empty inputs:** invader_collision=60 and no other hits, then frame → no event, ev_valid stays 0, busy stays 0.
- **Overrun:** hit (0,9) then frame with ev_ready=0; new hit (1,2) then a second frame while still draining → overrun pulses 1 cycle; after ready only {0,9} is delivered; a third frame yields no event.
- **Same-cycle collision and frame:** frame and invader_collision=33 asserted in the same cycle → 33 is not emitted for this frame; it is emitted after the next frame.
- **Reset mid-drain:** assert rst while in EMIT_PLY with two pending bits → ev_valid, busy and overrun are 0 immediately; the next frame with no captures produces no event.

Source files
------------

// File: rtl/collision_event_scheduler.sv
// Collects per-frame invader/player collision hits and replays each
// once per frame as a prioritized valid/ready event stream.
module collision_event_scheduler #(
    parameter int NUM_INVADERS = 55,
    parameter int NUM_MISSILES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic [5:0] invader_collision,
    input  logic [1:0] player_collision,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       ev_type,
    output logic [5:0] ev_index,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT_INV,
        EMIT_PLY
    } state_e;

    localparam logic [6:0] INV_MAX = 7'(NUM_INVADERS);
    localparam logic [2:0] MIS_MAX = 3'(NUM_MISSILES);

    state_e                  state_q, state_d;
    logic [5:0]              cap_inv_q, cap_inv_d;
    logic                    cap_inv_v_q, cap_inv_v_d;
    logic [NUM_MISSILES-1:0] cap_ply_q, cap_ply_d;
    logic [5:0]              pend_inv_q, pend_inv_d;
    logic                    pend_inv_v_q, pend_inv_v_d;
    logic [NUM_MISSILES-1:0] pend_ply_q, pend_ply_d;
    logic                    overrun_q, overrun_d;

    logic                    inv_ok;
    logic                    ply_ok;
    logic [5:0]              low_idx;
    logic [NUM_MISSILES-1:0] low_mask;

    assign inv_ok = (invader_collision != 6'd0)
                  && ({1'b0, invader_collision} <= INV_MAX);
    assign ply_ok = (player_collision != 2'd0)
                  && ({1'b0, player_collision} <= MIS_MAX);

    // Capture path: a frame pulse clears first, so same-cycle hits land
    // in the fresh registers and count toward the next frame.
    always_comb begin
        cap_inv_d   = frame ? 6'd0 : cap_inv_q;
        cap_inv_v_d = frame ? 1'b0 : cap_inv_v_q;
        cap_ply_d   = frame ? '0 : cap_ply_q;
        if (inv_ok && !cap_inv_v_d) begin
            cap_inv_d   = invader_collision;
            cap_inv_v_d = 1'b1;
        end
        for (int i = 0; i < NUM_MISSILES; i++) begin
            if (ply_ok && (int'(player_collision) == i + 1)) begin
                cap_ply_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        low_idx  = 6'd0;
        low_mask = '0;
        for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
            if (pend_ply_q[i]) begin
                low_idx     = 6'(i + 1);
                low_mask    = '0;
                low_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_inv_d   = pend_inv_q;
        pend_inv_v_d = pend_inv_v_q;
        pend_ply_d   = pend_ply_q;
        overrun_d    = frame && (state_q != IDLE);
        ev_valid     = 1'b0;
        ev_type      = 1'b0;
        ev_index     = 6'd0;
        unique case (state_q)
            IDLE: begin
                if (frame) begin
                    pend_inv_d   = cap_inv_q;
                    pend_inv_v_d = cap_inv_v_q;
                    pend_ply_d   = cap_ply_q;
                    if (cap_inv_v_q) begin
                        state_d = EMIT_INV;
                    end else if (cap_ply_q != '0) begin
                        state_d = EMIT_PLY;
                    end
                end
            end
            EMIT_INV: begin
                ev_valid = 1'b1;
                ev_index = pend_inv_q;
                if (ev_ready) begin
                    pend_inv_v_d = 1'b0;
                    state_d = (pend_ply_q != '0) ? EMIT_PLY : IDLE;
                end
            end
            EMIT_PLY: begin
                ev_valid = 1'b1;
                ev_type  = 1'b1;
                ev_index = low_idx;
                if (ev_ready) begin
                    pend_ply_d = pend_ply_q & ~low_mask;
                    if (pend_ply_d == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cap_inv_q    <= 6'd0;
            cap_inv_v_q  <= 1'b0;
            cap_ply_q    <= '0;
            pend_inv_q   <= 6'd0;
            pend_inv_v_q <= 1'b0;
            pend_ply_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_inv_q    <= cap_inv_d;
            cap_inv_v_q  <= cap_inv_v_d;
            cap_ply_q    <= cap_ply_d;
            pend_inv_q   <= pend_inv_d;
            pend_inv_v_q <= pend_inv_v_d;
            pend_ply_q   <= pend_ply_d;
            overrun_q    <= overrun_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Directed table-driven bench for collision_event_scheduler, plus
// hand-written overrun and reset-mid-drain sequences.
module tb_collision_event_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame;
    logic [5:0] invader_collision;
    logic [1:0] player_collision;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_type;
    logic [5:0] ev_index;
    logic       busy;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    collision_event_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .frame            (frame),
        .invader_collision(invader_collision),
        .player_collision (player_collision),
        .ev_valid         (ev_valid),
        .ev_ready         (ev_ready),
        .ev_type          (ev_type),
        .ev_index         (ev_index),
        .busy             (busy),
        .overrun          (overrun)
    );

    typedef struct {
        logic [5:0] inv;
        logic [1:0] ply;
        logic       frm;
        logic       rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Output tuple: {valid, type, index[5:0], busy, overrun}
    function automatic logic [9:0] ex(logic v, logic t, logic [5:0] idx,
                                      logic b, logic o);
        return {v, t, idx, b, o};
    endfunction

    function automatic vec_t mk(logic [5:0] inv, logic [1:0] ply,
                                logic frm, logic rdy, logic [9:0] exp);
        vec_t r;
        r.inv = inv;
        r.ply = ply;
        r.frm = frm;
        r.rdy = rdy;
        r.exp = exp;
        return r;
    endfunction

    task automatic chk(string nm, logic [9:0] exp);
        logic [9:0] act;
        act = {ev_valid, ev_type, ev_index, busy, overrun};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got v%b t%b idx%0d busy%b ovr%b, want v%b t%b idx%0d busy%b ovr%b",
                     nm, act[9], act[8], act[7:2], act[1], act[0],
                     exp[9], exp[8], exp[7:2], exp[1], exp[0]);
        end
    endtask

    // Drive inputs for one cycle, check outputs mid-cycle, then step.
    task automatic go(string nm, logic [5:0] inv, logic [1:0] ply,
                      logic frm, logic rdy, logic [9:0] exp);
        invader_collision = inv;
        player_collision  = ply;
        frame             = frm;
        ev_ready          = rdy;
        @(negedge clk);
        chk(nm, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] z;
        z = 10'd0;
        rst = 1'b1;
        frame = 1'b0;
        invader_collision = 6'd0;
        player_collision = 2'd0;
        ev_ready = 1'b0;

        // invader 17 repeated, then 20 ignored
        for (int i = 0; i < 4; i++) tbl.push_back(mk(17, 0, 0, 0, z));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(20, 0, 0, 0, z));
        tbl.push_back(mk(0, 0, 1, 1, z));
        tbl.push_back(mk(0, 0, 0, 1, ex(1, 0, 17, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 1, z));
        // mixed hits, 3-cycle stall
        tbl.push_back(mk(0, 3, 0, 0, z));
        tbl.push_back(mk(5, 1, 0, 0, z));
        tbl.push_back(mk(0, 0, 1, 0, z));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, ex(1, 0, 5, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 1, ex(1, 0, 5, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 1, ex(1, 1, 1, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 1, ex(1, 1, 3, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 0, z));
        // out-of-range invader only
        tbl.push_back(mk(60, 0, 0, 1, z));
        tbl.push_back(mk(0, 0, 1, 1, z));
        tbl.push_back(mk(0, 0, 0, 1, z));
        tbl.push_back(mk(0, 0, 0, 1, z));
        // hit in the frame cycle belongs to the next frame
        tbl.push_back(mk(33, 0, 1, 1, z));
        tbl.push_back(mk(0, 0, 0, 1, z));
        tbl.push_back(mk(0, 0, 1, 1, z));
        tbl.push_back(mk(0, 0, 0, 1, ex(1, 0, 33, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 1, z));
        // player-only frame, repeated missile
        tbl.push_back(mk(0, 2, 0, 0, z));
        tbl.push_back(mk(0, 2, 0, 0, z));
        tbl.push_back(mk(0, 0, 1, 1, z));
        tbl.push_back(mk(0, 0, 0, 1, ex(1, 1, 2, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 1, z));

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_state", z);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            go($sformatf("row%0d", i), tbl[i].inv, tbl[i].ply,
               tbl[i].frm, tbl[i].rdy, tbl[i].exp);
        end

        // overrun: second frame while still stalled on {0,9}
        go("ovr_hit", 9, 0, 0, 0, z);
        go("ovr_frm1", 0, 0, 1, 0, z);
        go("ovr_cap", 0, 2, 0, 0, ex(1, 0, 9, 1, 0));
        go("ovr_frm2", 0, 0, 1, 0, ex(1, 0, 9, 1, 0));
        go("ovr_pulse", 0, 0, 0, 0, ex(1, 0, 9, 1, 1));
        go("ovr_gone", 0, 0, 0, 0, ex(1, 0, 9, 1, 0));
        go("ovr_xfer", 0, 0, 0, 1, ex(1, 0, 9, 1, 0));
        go("ovr_idle", 0, 0, 0, 1, z);
        go("ovr_frm3", 0, 0, 1, 1, z);
        go("ovr_none", 0, 0, 0, 1, z);
        go("ovr_none2", 0, 0, 0, 1, z);

        // reset while draining two missile bits with overrun high
        go("rst_p1", 0, 1, 0, 0, z);
        go("rst_p3", 0, 3, 0, 0, z);
        go("rst_frm", 0, 0, 1, 0, z);
        go("rst_ply", 0, 0, 0, 0, ex(1, 1, 1, 1, 0));
        go("rst_frm2", 0, 0, 1, 0, ex(1, 1, 1, 1, 0));
        frame = 1'b0;
        chk("rst_pre", ex(1, 1, 1, 1, 1));
        rst = 1'b1;
        #1;
        chk("rst_async", z);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        go("rst_frm3", 0, 0, 1, 1, z);
        go("rst_none", 0, 0, 0, 1, z);
        go("rst_none2", 0, 0, 0, 1, z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
